// File: rtl/runway_slot_if.sv
// runway_slot_if: allocation-record handshake and runway status bundle.
`default_nettype none

interface runway_slot_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_runway;
   logic [2:0] req_gate;
   logic [3:0] req_delay;
   logic       req_takeoff;
   logic [1:0] rwy_busy;
   logic [1:0] clear_go;
   logic [7:0] gate_occ;
   logic       err_pulse;

   modport master (
      output req_valid, req_runway, req_gate, req_delay, req_takeoff,
      input  req_ready, rwy_busy, clear_go, gate_occ, err_pulse
   );

   modport slave (
      input  req_valid, req_runway, req_gate, req_delay, req_takeoff,
      output req_ready, rwy_busy, clear_go, gate_occ, err_pulse
   );
endinterface

`default_nettype wire

// File: rtl/runway_slot_manager.sv
// runway_slot_manager: two runway channels (FREE/HOLD/OCC) with hold and occupancy countdowns and gate map.
// Optional: define EMERG_PREEMPT_EN to let emergency records preempt a channel in HOLD.
`default_nettype none

module runway_slot_manager #(
   parameter int OCC_SECS = 5,
   parameter int CNT_W    = 8
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        sec_tick,
   runway_slot_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_HOLD = 2'd1,
      ST_OCC  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_OCC_LD  = CNT_W'(OCC_SECS);

   logic [1:0]      w_free;
   logic [1:0]      w_sel;
   logic [1:0]      w_load;
   logic [1:0]      w_go;
   logic [1:0][7:0] w_clr_mask;
   logic [1:0][7:0] w_set_mask;
   logic            w_ready;
   logic            w_illegal;
   logic            w_preempt;
   logic            w_accept;
   logic            w_conflict;
   logic [7:0]      r_gate_occ;

`ifdef EMERG_PREEMPT_EN
   logic [1:0]      w_hold;
`endif

   always_comb begin
      w_sel     = 2'b00;
      w_ready   = 1'b0;
      w_illegal = 1'b0;
      w_preempt = 1'b0;
      case (bus.req_runway)
         2'b01: begin
            w_sel   = 2'b01;
            w_ready = w_free[0];
         end
         2'b10: begin
            w_sel   = 2'b10;
            w_ready = w_free[1];
         end
         2'b00: begin
            if (w_free[0]) begin
               w_sel   = 2'b01;
               w_ready = 1'b1;
            end else if (w_free[1]) begin
               w_sel   = 2'b10;
               w_ready = 1'b1;
            end
`ifdef EMERG_PREEMPT_EN
            // OCC is never interrupted; only a channel still waiting in HOLD yields
            else if (w_hold[0]) begin
               w_sel     = 2'b01;
               w_ready   = 1'b1;
               w_preempt = 1'b1;
            end else if (w_hold[1]) begin
               w_sel     = 2'b10;
               w_ready   = 1'b1;
               w_preempt = 1'b1;
            end
`endif
         end
         default: begin
            w_ready   = 1'b1;
            w_illegal = 1'b1;
         end
      endcase
   end

   assign w_accept   = bus.req_valid & w_ready & rst_n;
   assign w_load     = w_sel & {2{w_accept}};
   assign w_conflict = bus.req_takeoff ? ~r_gate_occ[bus.req_gate] : r_gate_occ[bus.req_gate];

   assign bus.req_ready = w_ready & rst_n;
   assign bus.err_pulse = w_accept & (w_illegal | w_preempt | w_conflict);
   assign bus.rwy_busy  = ~w_free;
   assign bus.clear_go  = w_go;
   assign bus.gate_occ  = r_gate_occ;

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      state_t           r_state, w_state_nxt;
      logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
      logic [2:0]       r_gate, w_gate_nxt;
      logic             r_takeoff, w_takeoff_nxt;
      logic             w_rel;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state   <= ST_FREE;
            r_cnt     <= '0;
            r_gate    <= '0;
            r_takeoff <= 1'b0;
         end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gate    <= w_gate_nxt;
            r_takeoff <= w_takeoff_nxt;
         end
      end

      always_comb begin
         w_state_nxt   = r_state;
         w_cnt_nxt     = r_cnt;
         w_gate_nxt    = r_gate;
         w_takeoff_nxt = r_takeoff;
         w_go[gi]      = 1'b0;
         w_rel         = 1'b0;
         if (w_load[gi]) begin
            w_state_nxt   = ST_HOLD;
            w_cnt_nxt     = CNT_W'(bus.req_delay);
            w_gate_nxt    = bus.req_gate;
            w_takeoff_nxt = bus.req_takeoff;
         end else begin
            case (r_state)
               ST_HOLD: begin
                  if (r_cnt == '0) begin
                     w_state_nxt = ST_OCC;
                     w_cnt_nxt   = c_OCC_LD;
                     w_go[gi]    = 1'b1;
                  end else if (sec_tick) begin
                     w_cnt_nxt = r_cnt - c_CNT_ONE;
                  end
               end
               ST_OCC: begin
                  if (r_cnt == '0) begin
                     w_state_nxt = ST_FREE;
                     w_rel       = 1'b1;
                  end else if (sec_tick) begin
                     w_cnt_nxt = r_cnt - c_CNT_ONE;
                  end
               end
               default: ;
            endcase
         end
      end

      assign w_free[gi]     = (r_state == ST_FREE);
      assign w_clr_mask[gi] = (w_rel &&  r_takeoff) ? (8'h01 << r_gate) : 8'h00;
      assign w_set_mask[gi] = (w_rel && !r_takeoff) ? (8'h01 << r_gate) : 8'h00;
`ifdef EMERG_PREEMPT_EN
      assign w_hold[gi]     = (r_state == ST_HOLD);
`endif
   end

   // Clears land before sets so a simultaneous landing release on the same gate wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate_occ <= '0;
      end else begin
         r_gate_occ <= (r_gate_occ & ~(w_clr_mask[0] | w_clr_mask[1]))
                       | (w_set_mask[0] | w_set_mask[1]);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_runway_slot_manager.sv
// tb_runway_slot_manager: vector table, directed corner sequences and randomized run against a deadline model.
`default_nettype none

module tb_runway_slot_manager;
   localparam int OCC = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sec_tick = 1'b0;
   int   total = 0;
   int   bad = 0;

   runway_slot_if bus();

   runway_slot_manager #(.OCC_SECS(OCC), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sec_tick (sec_tick),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input bit v, input bit [1:0] rw, input bit [2:0] g,
                        input bit [3:0] d, input bit to, input bit tk);
      bus.req_valid   = v;
      bus.req_runway  = rw;
      bus.req_gate    = g;
      bus.req_delay   = d;
      bus.req_takeoff = to;
      sec_tick        = tk;
   endtask

   // ---------------- reference model: absolute tick deadlines ----------------
   int          ph [2];   // 0 free, 1 holding, 2 occupied
   longint      due [2];  // tick count at which the current phase may end
   int          mg [2];
   bit          mto [2];
   logic [7:0]  mocc;
   longint      T;
   bit          e_rdy, e_err, e_acc;
   logic [1:0]  e_clr, e_busy;
   int          e_sel;

   task automatic m_reset();
      for (int r = 0; r < 2; r++) begin
         ph[r] = 0; due[r] = 0; mg[r] = 0; mto[r] = 0;
      end
      mocc = 8'h00;
      T = 0;
   endtask

   task automatic m_eval(input bit v, input bit [1:0] rw, input bit [2:0] g, input bit to);
      bit pre;
      pre = 0; e_sel = -1; e_rdy = 0;
      case (rw)
         2'd1: begin e_sel = 0; e_rdy = (ph[0] == 0); end
         2'd2: begin e_sel = 1; e_rdy = (ph[1] == 0); end
         2'd0: begin
            if (ph[0] == 0) begin e_sel = 0; e_rdy = 1; end
            else if (ph[1] == 0) begin e_sel = 1; e_rdy = 1; end
`ifdef EMERG_PREEMPT_EN
            else if (ph[0] == 1) begin e_sel = 0; e_rdy = 1; pre = 1; end
            else if (ph[1] == 1) begin e_sel = 1; e_rdy = 1; pre = 1; end
`endif
         end
         default: e_rdy = 1;
      endcase
      e_acc = v && e_rdy;
      e_err = e_acc && (rw == 2'd3 || pre || (e_sel >= 0 && (to ? !mocc[g] : mocc[g])));
      for (int r = 0; r < 2; r++) begin
         e_busy[r] = (ph[r] != 0);
         e_clr[r]  = (ph[r] == 1) && (T >= due[r]) && !(e_acc && e_sel == r);
      end
   endtask

   task automatic m_step(input bit tk, input bit [2:0] g, input bit [3:0] d, input bit to);
      longint     tn;
      logic [7:0] cm, sm;
      tn = T + tk; cm = 8'h00; sm = 8'h00;
      for (int r = 0; r < 2; r++) begin
         if (e_acc && e_sel == r) begin
            ph[r] = 1; due[r] = tn + d; mg[r] = g; mto[r] = to;
         end else if (ph[r] == 1 && T >= due[r]) begin
            ph[r] = 2; due[r] = tn + OCC;
         end else if (ph[r] == 2 && T >= due[r]) begin
            ph[r] = 0;
            if (mto[r]) cm[mg[r]] = 1'b1;
            else        sm[mg[r]] = 1'b1;
         end
      end
      mocc = (mocc & ~cm) | sm;
      T = tn;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
   endtask

   // one idle cycle expecting the given ready value
   task automatic idle_rdy(input string nm, input int idx, input bit [1:0] rw, input bit tk, input bit rdy);
      drive(0, rw, 0, 0, 0, tk);
      @(negedge clk);
      chk(nm, idx, bus.req_ready, rdy);
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit v; bit [1:0] rw; bit [2:0] g; bit [3:0] d; bit to; bit tk;
      bit rdy; bit err; bit [1:0] clr; bit [1:0] busy; bit [7:0] occ;
   } vec_t;

   vec_t tbl [23];

   initial begin
      bit         pv, tk, v;
      bit [1:0]   rw;
      bit [2:0]   g;
      bit [3:0]   d;
      bit         to;
      int         seen;

      //            v rw g  d to tk  rdy err clr    busy   occ
      tbl[0]  = '{0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 8'h00};
      tbl[1]  = '{1, 1, 2, 0, 0, 0,  1, 0, 2'b00, 2'b00, 8'h00};
      tbl[2]  = '{0, 1, 0, 0, 0, 0,  0, 0, 2'b01, 2'b01, 8'h00};
      tbl[3]  = '{0, 1, 0, 0, 0, 1,  0, 0, 2'b00, 2'b01, 8'h00};
      tbl[4]  = '{0, 1, 0, 0, 0, 1,  0, 0, 2'b00, 2'b01, 8'h00};
      tbl[5]  = '{0, 1, 0, 0, 0, 1,  0, 0, 2'b00, 2'b01, 8'h00};
      tbl[6]  = '{0, 1, 0, 0, 0, 1,  0, 0, 2'b00, 2'b01, 8'h00};
      tbl[7]  = '{0, 1, 0, 0, 0, 1,  0, 0, 2'b00, 2'b01, 8'h00};
      tbl[8]  = '{0, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b01, 8'h00};
      tbl[9]  = '{0, 1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 8'h04};
      tbl[10] = '{1, 3, 7, 3, 0, 0,  1, 1, 2'b00, 2'b00, 8'h04};
      tbl[11] = '{0, 2, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 8'h04};
      tbl[12] = '{1, 2, 6, 0, 1, 0,  1, 1, 2'b00, 2'b00, 8'h04};
      tbl[13] = '{0, 2, 0, 0, 0, 0,  0, 0, 2'b10, 2'b10, 8'h04};
      tbl[14] = '{1, 0, 3, 2, 0, 0,  1, 0, 2'b00, 2'b10, 8'h04};
      tbl[15] = '{0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b11, 8'h04};
      tbl[16] = '{0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b11, 8'h04};
      tbl[17] = '{0, 0, 0, 0, 0, 0,  0, 0, 2'b01, 2'b11, 8'h04};
      tbl[18] = '{0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b11, 8'h04};
      tbl[19] = '{0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b11, 8'h04};
      tbl[20] = '{0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b11, 8'h04};
      tbl[21] = '{0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b11, 8'h04};
      tbl[22] = '{0, 0, 0, 0, 0, 0,  1, 0, 2'b00, 2'b01, 8'h04};

      do_reset();
      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].v, tbl[i].rw, tbl[i].g, tbl[i].d, tbl[i].to, tbl[i].tk);
         @(negedge clk);
         chk("vec_rdy",  i, bus.req_ready, tbl[i].rdy);
         chk("vec_err",  i, bus.err_pulse, tbl[i].err);
         chk("vec_clr",  i, bus.clear_go,  tbl[i].clr);
         chk("vec_busy", i, bus.rwy_busy,  tbl[i].busy);
         chk("vec_occ",  i, bus.gate_occ,  tbl[i].occ);
         @(posedge clk); #1;
      end

      // delay 12 on runway1 with a second runway1 record stalled behind it
      do_reset();
      drive(1, 1, 4, 12, 0, 0);
      @(negedge clk); chk("d12_acc", 0, bus.req_ready, 1);
      @(posedge clk); #1;
      for (int k = 1; k <= 12; k++) begin
         drive(1, 1, 5, 3, 0, 1);
         @(negedge clk);
         chk("d12_stall", k, bus.req_ready, 0);
         chk("d12_nogo",  k, bus.clear_go, 2'b00);
         @(posedge clk); #1;
      end
      drive(1, 1, 5, 3, 0, 0);
      @(negedge clk);
      chk("d12_go",  0, bus.clear_go, 2'b01);
      chk("d12_rdy", 0, bus.req_ready, 0);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         drive(1, 1, 5, 3, 0, 1);
         @(negedge clk); chk("d12_occ_stall", k, bus.req_ready, 0);
         @(posedge clk); #1;
      end
      drive(1, 1, 5, 3, 0, 0);
      @(negedge clk); chk("d12_last", 0, bus.req_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("d12_free", 0, bus.req_ready, 1);
      chk("d12_gate", 0, bus.gate_occ, 8'h10);
      @(posedge clk); #1;

      // reset during HOLD with 7 seconds left
      do_reset();
      drive(1, 2, 1, 9, 0, 0);
      @(posedge clk); #1;
      idle_rdy("rst_hold", 0, 2'd2, 1, 0);
      idle_rdy("rst_hold", 1, 2'd2, 1, 0);
      drive(0, 2, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 0, bus.rwy_busy, 2'b00);
      chk("rst_go",   0, bus.clear_go, 2'b00);
      chk("rst_occ",  0, bus.gate_occ, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         drive(0, 2, 0, 0, 0, 1);
         @(negedge clk);
         if (bus.clear_go != 2'b00 || bus.rwy_busy != 2'b00) seen++;
         @(posedge clk); #1;
      end
      chk("rst_quiet", 0, seen, 0);

      // land at gate 5 on runway2, then take off from it
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         drive(1, 2, 5, 0, pass[0], 0);
         @(negedge clk); chk("g5_err", pass, bus.err_pulse, 0);
         @(posedge clk); #1;
         idle_rdy("g5_clr", pass, 2'd2, 0, 0);
         for (int k = 0; k < OCC; k++) idle_rdy("g5_occ", pass, 2'd2, 1, 0);
         idle_rdy("g5_rel", pass, 2'd2, 0, 0);
         @(negedge clk);
         chk("g5_map", pass, bus.gate_occ, (pass == 0) ? 8'h20 : 8'h00);
         @(posedge clk); #1;
      end

      // randomized run against the deadline model
      do_reset();
      pv = 0; rw = 0; g = 0; d = 0; to = 0;
      for (int c = 0; c < 4000; c++) begin
         if (!pv && $urandom_range(0, 2) == 0) begin
            pv = 1;
            rw = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            g  = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            d  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            to = 1'($urandom_range(0, 1));
         end
         tk = ($urandom_range(0, 2) == 0);
         v  = pv;
         if (pv) drive(1, rw, g, d, to, tk);
         else    drive(0, 2'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), tk);
         @(negedge clk);
         m_eval(v, bus.req_runway, bus.req_gate, bus.req_takeoff);
         chk("rand", c,
             {bus.req_ready, bus.err_pulse, bus.clear_go, bus.rwy_busy, bus.gate_occ},
             {e_rdy, e_err, e_clr, e_busy, mocc});
         @(posedge clk);
         m_step(tk, bus.req_gate, bus.req_delay, bus.req_takeoff);
         if (e_acc) pv = 0;
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/runway_slot_manager.md
Name: runway_slot_manager

Overview:
- Downstream of the air-traffic allocation stage. Accepts one allocation record per handshake: runway code, gate, hold delay and a landing/takeoff flag.
- Runs the weather/fuel hold countdown and the runway-occupancy countdown for each of the two physical runways.
- Owns the authoritative runway-busy flags and the gate-occupancy bitmap that the allocation stage reads back.

Parameters:
- OCC_SECS, 5, seconds a runway stays occupied after clearance; range 1..2^CNT_W-1.
- CNT_W, 8, width of the per-runway occupancy counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- sec_tick  in  1  one-cycle pulse, once per second
- req_valid  in  1  allocation record valid
- req_ready  out  1  record accepted this cycle when high with req_valid
- req_runway  in  2  00 emergency (any runway), 01 runway1, 10 runway2, 11 illegal
- req_gate  in  3  gate number 0..7
- req_delay  in  4  hold seconds before clearance, 0..15
- req_takeoff  in  1  1 = takeoff, 0 = landing
- rwy_busy  out  2  bit0 runway1, bit1 runway2; high when the channel is not FREE
- clear_go  out  2  one-cycle pulse per runway on HOLD->OCC (clearance issued)
- gate_occ  out  8  gate-occupancy bitmap
- err_pulse  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: rwy_busy=0, clear_go=0, gate_occ=0, err_pulse=0, both channels FREE, all counters 0. Reset mid-operation discards all in-flight holds and occupancies.
- Channel FSM, one per runway, with states FREE, HOLD, OCC:
  - FREE->HOLD on accept; hold counter <= req_delay; gate and takeoff flag latched.
  - HOLD: on sec_tick with cnt!=0, cnt<=cnt-1. When cnt==0, go to OCC next cycle, load cnt<=OCC_SECS and pulse clear_go. With req_delay=0 the pulse is one cycle after accept. With delay N it comes one cycle after the Nth tick.
  - OCC: on sec_tick with cnt!=0, cnt<=cnt-1. When cnt==0, go to FREE. Then landing sets gate_occ[gate] and takeoff clears gate_occ[gate]. rwy_busy drops in that same cycle.
- Target selection, combinational from req fields:
  - 01 -> runway1; 10 -> runway2.
  - 00 -> runway1 if FREE, else runway2.
  - 11 -> no target.
- req_ready:
  - For 01/10/00: high iff the selected target is FREE.
  - For 11: always high; the record is dropped and err_pulse fires.
- req_ready must not depend on req_valid.
- An accepted landing to a gate already set in gate_occ, or a takeoff from a gate already clear: the record still runs normally and err_pulse fires in the accept cycle.
- Both channels release the same gate in one cycle: clear is applied first, then set (set wins).
- A record held while req_ready is low must stay stable until accepted; the bench checks that no field is sampled except on the handshake.
- Counters never wrap below 0. A sec_tick in the same cycle as accept does not decrement the newly loaded value.

Optional Feature:
- Macro EMERG_PREEMPT_EN.
- Defined: an emergency request (00) with both runways busy preempts a channel in HOLD, runway1 checked first. That channel is reloaded with the emergency record, req_ready goes high and err_pulse fires to flag the dropped record. A channel in OCC is never preempted; if both are in OCC, req_ready stays low.
- Undefined: an emergency request stalls like any other until a runway is FREE.

Test Plan:
- Landing rwy 01, gate 2, delay 0, OCC_SECS=5 -> clear_go[0] one cycle after accept; rwy_busy[0]=1 for 5 ticks; then gate_occ=8'h04, rwy_busy=0.
- Landing rwy 01, delay 12 (bad weather) -> clear_go[0] one cycle after the 12th sec_tick; a second 01 request meanwhile sees req_ready=0 until the channel is FREE.
- Emergency 00 with runway1 busy -> routed to runway2; rwy_busy=2'b11; gate_occ updated on runway2 release.
- Takeoff rwy 10 from gate 5 with gate_occ[5]=1 -> bit 5 clears after OCC_SECS ticks. Takeoff from an empty gate 6 -> err_pulse in the accept cycle.
- req_runway=11 -> req_ready=1, err_pulse=1, no state change; rst_n low during HOLD with 7 seconds left -> all outputs 0 immediately, no clear_go afterward.
- With EMERG_PREEMPT_EN: runway1 in HOLD, runway2 in OCC, emergency arrives -> runway1 reloaded, err_pulse=1, clear_go[0] per the new delay.
